// File: rtl/tone_pkg.sv
// Shared types and default constants for the tone sequencer.
package tone_pkg;

    localparam int DIV_W_DEF    = 12;
    localparam int DUR_W_DEF    = 16;
    localparam int TICK_DIV_DEF = 1000;
    localparam int GAP_MS_DEF   = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } tone_state_e;

    typedef struct packed {
        logic [DIV_W_DEF-1:0] half_period;
        logic [DUR_W_DEF-1:0] dur;
    } note_t;

endpackage

// File: rtl/tone_tick_div.sv
// Duration prescaler: counts run cycles and emits a one-cycle tick every TICK_DIV of them.
module tone_tick_div #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk_1M,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // tick is independent of clear so a terminal tick can still end the GAP phase
    always_comb begin
        cnt_d = cnt_q;
        tick  = run && (cnt_q == LAST);
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_1M or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tone_seq_gen.sv
// Note-stream square-wave buzzer driver. Optional silent gap after each note: TONE_GAP_EN.
//   state | meaning
//   IDLE  | waiting for a note (note_ready high)
//   PLAY  | toggling beep_out every hp_r+1 enabled cycles for dur_r ticks
//   GAP   | silent pause of GAP_MS ticks after a note
module tone_seq_gen
    import tone_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEF,
    parameter int DUR_W    = DUR_W_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int GAP_MS   = GAP_MS_DEF
) (
    input  logic             clk_1M,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [DIV_W-1:0] note_half_period,
    input  logic [DUR_W-1:0] note_dur,
    output logic             beep_out,
    output logic             busy,
    output logic             note_done
);

`ifdef TONE_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif
    localparam logic [DUR_W-1:0] GAP_LAST = (GAP_MS > 0) ? DUR_W'(GAP_MS - 1) : '0;

    tone_state_e      state_q, state_d;
    logic [DIV_W-1:0] hp_q, hp_d;
    logic [DUR_W-1:0] dur_r_q, dur_r_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DUR_W-1:0] dur_cnt_q, dur_cnt_d;
    logic             phase_q, phase_d;
    logic             rdy_en_q, rdy_en_d;

    logic tick, tick_clear, tick_run;
    logic xfer, play_end, gap_end;

    tone_tick_div #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_1M (clk_1M),
        .rst_n  (rst_n),
        .run    (tick_run),
        .clear  (tick_clear),
        .tick   (tick)
    );

    assign note_ready = (state_q == IDLE) && rdy_en_q;
    assign busy       = (state_q != IDLE);
    assign tick_run   = enable && (state_q != IDLE);
    assign xfer       = note_valid && note_ready;
    assign play_end   = (state_q == PLAY) && enable && (dur_cnt_q == dur_r_q);
    assign gap_end    = (GAP_MS == 0) || (tick && (dur_cnt_q == GAP_LAST));
    // Phase is held through a pause and only gated at the pin.
    assign beep_out   = (state_q == PLAY) && enable && phase_q && !play_end;
    assign rdy_en_d   = 1'b1;

    always_comb begin
        state_d    = state_q;
        hp_d       = hp_q;
        dur_r_d    = dur_r_q;
        div_cnt_d  = div_cnt_q;
        dur_cnt_d  = dur_cnt_q;
        phase_d    = phase_q;
        note_done  = 1'b0;
        tick_clear = 1'b0;
        case (state_q)
            IDLE: begin
                tick_clear = 1'b1;
                if (xfer) begin
                    state_d   = PLAY;
                    hp_d      = note_half_period;
                    dur_r_d   = note_dur;
                    div_cnt_d = '0;
                    dur_cnt_d = '0;
                    phase_d   = 1'b0;
                end
            end
            PLAY: begin
                if (play_end) begin
                    note_done  = 1'b1;
                    tick_clear = 1'b1;
                    div_cnt_d  = '0;
                    dur_cnt_d  = '0;
                    phase_d    = 1'b0;
                    state_d    = GAP_EN ? GAP : IDLE;
                end else if (enable) begin
                    if (tick) begin
                        dur_cnt_d = dur_cnt_q + 1'b1;
                    end
                    if (div_cnt_q == hp_q) begin
                        div_cnt_d = '0;
                        if (hp_q != '0) begin
                            phase_d = ~phase_q;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end
                end
            end
            GAP: begin
                if (enable && gap_end) begin
                    state_d    = IDLE;
                    dur_cnt_d  = '0;
                    tick_clear = 1'b1;
                end else if (tick) begin
                    dur_cnt_d = dur_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_1M or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hp_q      <= '0;
            dur_r_q   <= '0;
            div_cnt_q <= '0;
            dur_cnt_q <= '0;
            phase_q   <= 1'b0;
            rdy_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hp_q      <= hp_d;
            dur_r_q   <= dur_r_d;
            div_cnt_q <= div_cnt_d;
            dur_cnt_q <= dur_cnt_d;
            phase_q   <= phase_d;
            rdy_en_q  <= rdy_en_d;
        end
    end

endmodule

// File: tb/tb_tone_seq_gen.sv
// Bench for tone_seq_gen: directed note table, reset/back-to-back sequences, random traffic vs a cycle-count model.
`timescale 1ns/1ps
module tb_tone_seq_gen;
    import tone_pkg::*;

    localparam int TD  = 10;
    localparam int GMS = 2;
`ifdef TONE_GAP_EN
    localparam int GAPC = GMS * TD;
`else
    localparam int GAPC = 0;
`endif

    logic        clk_1M = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        note_valid = 1'b0;
    logic [11:0] note_half_period = '0;
    logic [15:0] note_dur = '0;
    logic        note_ready, beep_out, busy, note_done;

    tone_seq_gen #(.DIV_W(12), .DUR_W(16), .TICK_DIV(TD), .GAP_MS(GMS)) dut (
        .clk_1M           (clk_1M),
        .rst_n            (rst_n),
        .enable           (enable),
        .note_valid       (note_valid),
        .note_ready       (note_ready),
        .note_half_period (note_half_period),
        .note_dur         (note_dur),
        .beep_out         (beep_out),
        .busy             (busy),
        .note_done        (note_done)
    );

    always #5 clk_1M = ~clk_1M;

    int total = 0;
    int bad = 0;
    int nprint = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (nprint < 40) $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
            nprint++;
        end
    endtask

    // Reference model: a note is defined by how many enabled cycles it has been playing.
    int m_st = 0;  // 0 idle, 1 playing, 2 gap
    int m_e = 0, m_g = 0, m_hp = 0, m_dur = 0;
    bit m_rdy = 1'b0;

    always @(negedge clk_1M) begin
        int e_done, e_beep, e_rdy, e_busy;
        #2;
        if (!rst_n) begin
            m_st  = 0;
            m_rdy = 1'b0;
        end
        e_done = (rst_n && m_st == 1 && enable && m_e == m_dur * TD) ? 1 : 0;
        e_beep = (rst_n && m_st == 1 && enable && e_done == 0 && m_hp != 0 &&
                  ((m_e / (m_hp + 1)) % 2) == 1) ? 1 : 0;
        e_rdy  = (rst_n && m_st == 0 && m_rdy) ? 1 : 0;
        e_busy = (rst_n && m_st != 0) ? 1 : 0;
        chk("m_note_done", int'(note_done), e_done);
        chk("m_beep_out", int'(beep_out), e_beep);
        chk("m_note_ready", int'(note_ready), e_rdy);
        chk("m_busy", int'(busy), e_busy);
    end

    always @(posedge clk_1M) begin
        if (!rst_n) begin
            m_st  = 0;
            m_rdy = 1'b0;
        end else begin
            case (m_st)
                0: if (note_valid && m_rdy) begin
                    m_st  = 1;
                    m_e   = 0;
                    m_hp  = int'(note_half_period);
                    m_dur = int'(note_dur);
                end
                1: if (enable) begin
                    if (m_e == m_dur * TD) begin
                        m_st = (GAPC > 0) ? 2 : 0;
                        m_g  = 0;
                    end else begin
                        m_e++;
                    end
                end
                default: if (enable) begin
                    if (m_g >= GAPC - 1) m_st = 0;
                    else m_g++;
                end
            endcase
            m_rdy = 1'b1;
        end
    end

    typedef struct {
        int hp;
        int dur;
        int p_at;
        int p_len;
        int exp_done;
        int exp_hi;
        int exp_rise;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[5];
        int k, hi, rise, done_k, rdy_k;
        logic prev;
        int xfer_c[3];
        int done_c[3];
        int nx, nd, viol;
        int hps[3];
        int durs[3];

        vt[0] = '{hp: 4, dur: 5, p_at: -1, p_len: 0, exp_done: 50, exp_hi: 25, exp_rise: 5};
        vt[1] = '{hp: 0, dur: 2, p_at: -1, p_len: 0, exp_done: 20, exp_hi: 0,  exp_rise: 0};
        vt[2] = '{hp: 3, dur: 0, p_at: -1, p_len: 0, exp_done: 0,  exp_hi: 0,  exp_rise: 0};
        vt[3] = '{hp: 2, dur: 4, p_at: 10, p_len: 7, exp_done: 47, exp_hi: 19, exp_rise: 8};
        vt[4] = '{hp: 1, dur: 1, p_at: -1, p_len: 0, exp_done: 10, exp_hi: 4,  exp_rise: 2};

        #2;
        chk("rst_ready", int'(note_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_beep", int'(beep_out), 0);
        chk("rst_done", int'(note_done), 0);
        @(negedge clk_1M);
        @(negedge clk_1M);
        rst_n = 1'b1;
        @(negedge clk_1M);
        #1 chk("ready_after_init", int'(note_ready), 1);

        // Directed note table
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_1M);
            enable = 1'b1;
            note_valid = 1'b1;
            note_half_period = 12'(vt[i].hp);
            note_dur = 16'(vt[i].dur);
            #1 chk("tbl_ready", int'(note_ready), 1);
            @(negedge clk_1M);
            note_valid = 1'b0;
            k = 0; hi = 0; rise = 0; done_k = -1; prev = 1'b0;
            while (k < 300) begin
                enable = !(k >= vt[i].p_at && k < vt[i].p_at + vt[i].p_len);
                #1;
                if (note_done) begin
                    done_k = k;
                    break;
                end
                hi += int'(beep_out);
                if (beep_out && !prev) rise++;
                prev = beep_out;
                @(negedge clk_1M);
                k++;
            end
            enable = 1'b1;
            chk("tbl_done_cycle", done_k, vt[i].exp_done);
            chk("tbl_high_cycles", hi, vt[i].exp_hi);
            chk("tbl_rises", rise, vt[i].exp_rise);
            rdy_k = -1;
            while (k < 400) begin
                @(negedge clk_1M);
                k++;
                #1;
                if (note_ready) begin
                    rdy_k = k;
                    break;
                end
            end
            chk("tbl_ready_cycle", rdy_k, vt[i].exp_done + 1 + GAPC);
        end

        // Asynchronous reset mid-note
        @(negedge clk_1M);
        note_valid = 1'b1;
        note_half_period = 12'd4;
        note_dur = 16'd3;
        @(negedge clk_1M);
        note_valid = 1'b0;
        repeat (7) @(negedge clk_1M);
        #1 chk("beep_before_rst", int'(beep_out), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_beep", int'(beep_out), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_ready", int'(note_ready), 0);
        @(negedge clk_1M);
        @(negedge clk_1M);
        rst_n = 1'b1;
        @(negedge clk_1M);
        #1 chk("ready_after_rst", int'(note_ready), 1);

        // Back-to-back notes with note_valid held high
        hps[0] = 1; durs[0] = 1;
        hps[1] = 2; durs[1] = 2;
        hps[2] = 0; durs[2] = 1;
        nx = 0; nd = 0; viol = 0;
        for (int j = 0; j < 3; j++) begin
            xfer_c[j] = -100;
            done_c[j] = -100;
        end
        @(negedge clk_1M);
        note_valid = 1'b1;
        note_half_period = 12'(hps[0]);
        note_dur = 16'(durs[0]);
        for (int c = 0; c < 300 && nd < 3; c++) begin
            #1;
            if (note_ready && busy) viol++;
            if (note_done) begin
                done_c[nd] = c;
                nd++;
            end
            if (note_valid && note_ready) begin
                xfer_c[nx] = c;
                nx++;
            end
            @(negedge clk_1M);
            if (nx == 3) begin
                note_valid = 1'b0;
            end else begin
                note_half_period = 12'(hps[nx]);
                note_dur = 16'(durs[nx]);
            end
        end
        note_valid = 1'b0;
        chk("b2b_done_count", nd, 3);
        chk("b2b_xfer2", xfer_c[1], done_c[0] + 1 + GAPC);
        chk("b2b_xfer3", xfer_c[2], done_c[1] + 1 + GAPC);
        chk("b2b_ready_while_busy", viol, 0);
        repeat (40) @(negedge clk_1M);

        // Random traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_1M);
            if (c == 1500) begin
                rst_n = 1'b0;
            end else begin
                rst_n = 1'b1;
            end
            enable = ($urandom_range(0, 7) != 0);
            note_valid = ($urandom_range(0, 1) == 1);
            note_half_period = 12'($urandom_range(0, 5));
            note_dur = 16'($urandom_range(0, 3));
        end
        @(negedge clk_1M);
        note_valid = 1'b0;
        enable = 1'b1;
        repeat (80) @(negedge clk_1M);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
